// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map and TCON layout for timer_bank
// Purpose: offset constants, TCON bit positions and channel stride used by
//          timer_bank and timer_channel.
// Ports:   none (package).
package timer_pkg;

    // Byte offsets within the 256-byte register window (addr[7:0]).
    localparam logic [7:0] OFF_TH      = 8'h00;
    localparam logic [7:0] OFF_TL      = 8'h04;
    localparam logic [7:0] OFF_TCON    = 8'h08;
    localparam logic [7:0] OFF_PRESC   = 8'h0C;
    localparam logic [7:0] OFF_SYSTICK = 8'hF0;
    localparam logic [7:0] OFF_PEND    = 8'hF4;

    // TCON bit positions.
    localparam int EN      = 0;
    localparam int IRQ_EN  = 1;
    localparam int STATUS  = 2;
    localparam int ONESHOT = 3;

    // Byte distance between consecutive channel register blocks.
    localparam int CH_STRIDE = 16;

    // Word index of a register inside a channel block (addr[1:0] ignored).
    function automatic logic [1:0] reg_index(input logic [7:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one reload timer: TH, TL, TCON, PRESC and prescaler
// Purpose: prescaled up-counter with reload on overflow, optional one-shot,
//          sticky status flag that software may clear but never set.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   wr_en        bus write addressed to this channel's block
//   reg_idx      word index inside the block (TH/TL/TCON/PRESC)
//   wdata        bus write data
//   pend_clr     PEND write with this channel's bit set
//   rd_data      zero-extended value of the register at reg_idx
//   status       overflow status flag
//   irq_en       interrupt enable bit
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  reg_idx,
    input  logic [31:0] wdata,
    input  logic        pend_clr,
    output logic [31:0] rd_data,
    output logic        status,
    output logic        irq_en
);

    localparam logic [1:0] IDX_TH    = reg_index(OFF_TH);
    localparam logic [1:0] IDX_TL    = reg_index(OFF_TL);
    localparam logic [1:0] IDX_TCON  = reg_index(OFF_TCON);
    localparam logic [1:0] IDX_PRESC = reg_index(OFF_PRESC);

    logic [CNT_W-1:0]   th_q, th_d;
    logic [CNT_W-1:0]   tl_q, tl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
    logic               en_q, en_d;
    logic               irq_en_q, irq_en_d;
    logic               status_q, status_d;
    logic               oneshot_q, oneshot_d;

    logic wr_th, wr_tl, wr_tcon, wr_presc;
    logic tick, overflow;

    always_comb begin
        wr_th    = wr_en && (reg_idx == IDX_TH);
        wr_tl    = wr_en && (reg_idx == IDX_TL);
        wr_tcon  = wr_en && (reg_idx == IDX_TCON);
        wr_presc = wr_en && (reg_idx == IDX_PRESC);
    end

    always_comb begin
        // Tick and overflow use the registered controls, so TCON/PRESC
        // writes only influence the following cycle.
        tick     = en_q && (pre_cnt_q == presc_q);
        overflow = tick && (tl_q == {CNT_W{1'b1}});

        pre_cnt_d = '0;
        if (en_q && !tick) begin
            pre_cnt_d = pre_cnt_q + PRESC_W'(1);
        end

        th_d    = wr_th    ? wdata[CNT_W-1:0]   : th_q;
        presc_d = wr_presc ? wdata[PRESC_W-1:0] : presc_q;

        tl_d = tl_q;
        if (tick) begin
            tl_d = overflow ? th_q : tl_q + CNT_W'(1);
        end
        // A TL write overrides the count; the concurrent tick is dropped.
        if (wr_tl) begin
            tl_d = wdata[CNT_W-1:0];
        end

        en_d      = en_q;
        irq_en_d  = irq_en_q;
        oneshot_d = oneshot_q;
        status_d  = status_q;
        if (wr_tcon) begin
            en_d      = wdata[EN];
            irq_en_d  = wdata[IRQ_EN];
            oneshot_d = wdata[ONESHOT];
            // Software may only clear status through TCON.
            status_d  = wdata[STATUS] & status_q;
        end
        if (pend_clr) begin
            status_d = 1'b0;
        end
        // Overflow comes last: its status set beats any clear, and a
        // one-shot stop beats a concurrent enable write.
        if (overflow) begin
            if (irq_en_q) begin
                status_d = 1'b1;
            end
            if (oneshot_q) begin
                en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            presc_q   <= '0;
            pre_cnt_q <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            status_q  <= 1'b0;
            oneshot_q <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            presc_q   <= presc_d;
            pre_cnt_q <= pre_cnt_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            status_q  <= status_d;
            oneshot_q <= oneshot_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (reg_idx == IDX_TH) begin
            rd_data[CNT_W-1:0] = th_q;
        end else if (reg_idx == IDX_TL) begin
            rd_data[CNT_W-1:0] = tl_q;
        end else if (reg_idx == IDX_TCON) begin
            rd_data[EN]      = en_q;
            rd_data[IRQ_EN]  = irq_en_q;
            rd_data[STATUS]  = status_q;
            rd_data[ONESHOT] = oneshot_q;
        end else begin
            rd_data[PRESC_W-1:0] = presc_q;
        end
    end

    assign status = status_q;
    assign irq_en = irq_en_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - memory-mapped bank of reload timers plus Systick
// Purpose: address decode, read mux, free-running Systick and the
//          registered interrupt OR over N_CH timer_channel instances.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   addr                byte address; addr[31:16] selects, addr[7:2] decodes
//   wdata               write data
//   mem_read, mem_write read / write strobes
//   rdata               combinational read data, 0 when not selected
//   irq                 registered OR of (status & irq_en) over channels
//   systick             free-running cycle counter
module timer_bank
    import timer_pkg::*;
#(
    parameter int          N_CH    = 2,
    parameter int          CNT_W   = 32,
    parameter int          PRESC_W = 16,
    parameter logic [15:0] BASE_HI = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [31:0] systick
);

    logic        sel;
    logic [7:0]  off;
    logic        wr_en;
    logic        pend_wr;

    logic [31:0] systick_q, systick_d;
    logic        irq_q, irq_d;

    logic [N_CH-1:0] ch_hit;
    logic [N_CH-1:0] ch_status;
    logic [N_CH-1:0] ch_irq_en;
    logic [31:0]     ch_rdata [N_CH];

    // addr[15:8] is outside the window and addr[1:0] is the byte lane.
    logic unused_addr;
    assign unused_addr = ^{addr[15:8], addr[1:0]};

    always_comb begin
        sel     = (addr[31:16] == BASE_HI);
        off     = {addr[7:2], 2'b00};
        wr_en   = mem_write && sel;
        pend_wr = wr_en && (off == OFF_PEND);
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam logic [7:0] CH_BASE = 8'(c * CH_STRIDE);

        // N_CH <= 15, so channel blocks never alias the global 0xF0 block.
        assign ch_hit[c] = sel && (off[7:4] == CH_BASE[7:4]);

        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_en && ch_hit[c]),
            .reg_idx  (off[3:2]),
            .wdata    (wdata),
            .pend_clr (pend_wr && wdata[c]),
            .rd_data  (ch_rdata[c]),
            .status   (ch_status[c]),
            .irq_en   (ch_irq_en[c])
        );
    end

    always_comb begin
        systick_d = systick_q + 32'd1;
        irq_d     = |(ch_status & ch_irq_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            systick_q <= systick_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (mem_read && sel) begin
            if (off == OFF_SYSTICK) begin
                rdata = systick_q;
            end else if (off == OFF_PEND) begin
                rdata[N_CH-1:0] = ch_status;
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (ch_hit[c]) begin
                        rdata = ch_rdata[c];
                    end
                end
            end
        end
    end

    assign irq     = irq_q;
    assign systick = systick_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - scoreboard bench for timer_bank
module tb_timer_bank;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] systick;

    always #50 clk = ~clk;

    timer_bank #(
        .N_CH    (2),
        .CNT_W   (32),
        .PRESC_W (16),
        .BASE_HI (16'h4000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rdata     (rdata),
        .irq       (irq),
        .systick   (systick)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] win(input logic [7:0] off);
        return {16'h4000, 8'h00, off};
    endfunction

    // One write occupies exactly one rising edge; returns on the next falling edge.
    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        addr      = win(off);
        wdata     = d;
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    // Combinational read, sampled 1 time unit after drive; spans no edge.
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr     = a;
        mem_read = 1'b1;
        #1;
        d        = rdata;
        mem_read = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input string n);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        logic [7:0]  offs [13] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                   8'h1C, 8'hF0, 8'hF4, 8'hF8, 8'h20, 8'h30};
        exp_t        e;
        logic [31:0] got;
        // Reset released on a falling edge; no rising edge since, so SYSTICK is 0.
        foreach (offs[i]) push(win(offs[i]), 32'h0, $sformatf("reset_off_%02h", offs[i]));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b, expected 0", irq);
        end
        // Sampling on the falling edge makes the count exact: 10 edges, 10 counts.
        repeat (10) @(negedge clk);
        push(win(OFF_SYSTICK), 32'd10, "systick_10");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
    endtask

    task automatic test_autoreload;
        exp_t        e;
        logic [31:0] got;
        logic        irq_exp;
        wr(OFF_TH,    32'hFFFF_FFFC);
        wr(OFF_TL,    32'hFFFF_FFFC);
        wr(OFF_PRESC, 32'h0);
        wr(OFF_TCON,  32'h3);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            push(win(OFF_TL),   32'hFFFF_FFFC + 32'(i % 4), $sformatf("ar_tl_%0d", i));
            push(win(OFF_TCON), (i >= 4) ? 32'h7 : 32'h3,   $sformatf("ar_tcon_%0d", i));
            irq_exp = (i >= 5);
            checks++;
            if (irq !== irq_exp) begin
                failures++;
                $display("FAIL ar_irq_%0d: got %b, expected %b", i, irq, irq_exp);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rd(e.addr, got);
                checks++;
                if (got !== e.data) begin
                    failures++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
                end
            end
        end
        wr(OFF_TCON, 32'h0);
    endtask

    task automatic test_oneshot;
        exp_t        e;
        logic [31:0] got;
        logic        irq_exp;
        wr(8'h1C, 32'd2);
        wr(8'h10, 32'hFFFF_FFFE);
        wr(8'h14, 32'hFFFF_FFFE);
        wr(8'h18, 32'hB);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            push(win(8'h14), (i < 3) ? 32'hFFFF_FFFE : (i < 6) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE,
                 $sformatf("os_tl_%0d", i));
            push(win(8'h18), (i < 6) ? 32'hB : 32'hE, $sformatf("os_tcon_%0d", i));
            irq_exp = (i >= 7);
            checks++;
            if (irq !== irq_exp) begin
                failures++;
                $display("FAIL os_irq_%0d: got %b, expected %b", i, irq, irq_exp);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                rd(e.addr, got);
                checks++;
                if (got !== e.data) begin
                    failures++;
                    $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
                end
            end
        end
        // Drop irq_en but keep status: irq falls one cycle later, status remains.
        wr(8'h18, 32'h4);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irqen_clr_hold: got %b, expected 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irqen_clr_drop: got %b, expected 0", irq);
        end
        push(win(8'h18), 32'h4, "irqen_clr_tcon");
        push(win(OFF_PEND), 32'h2, "irqen_clr_pend");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        wr(8'h18, 32'h0);
    endtask

    task automatic test_set_wins;
        exp_t        e;
        logic [31:0] got;
        wr(OFF_TH,   32'hFFFF_FFFC);
        wr(OFF_TL,   32'hFFFF_FFFC);
        wr(OFF_TCON, 32'h3);
        repeat (3) @(negedge clk);
        // This write lands on the overflow edge.
        wr(OFF_PEND, 32'h1);
        push(win(OFF_TCON), 32'h7,         "sw_tcon");
        push(win(OFF_PEND), 32'h1,         "sw_pend");
        push(win(OFF_TL),   32'hFFFF_FFFC, "sw_tl");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        wr(OFF_PEND, 32'h1);
        push(win(OFF_TCON), 32'h3, "clr_tcon");
        push(win(OFF_PEND), 32'h0, "clr_pend");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL clr_irq_hold: got %b, expected 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL clr_irq_drop: got %b, expected 0", irq);
        end
    endtask

    task automatic test_write_vs_tick;
        exp_t        e;
        logic [31:0] got;
        // ch0 is ticking every cycle with TL = 0xFFFFFFFE here.
        wr(OFF_TL, 32'h5);
        push(win(OFF_TL), 32'h5, "wt_tl_write");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        @(negedge clk);
        push(win(OFF_TL), 32'h6, "wt_tl_next");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        wr(OFF_TCON, 32'h7);
        push(win(OFF_TCON), 32'h3, "wt_status_noset");
        push(win(OFF_TL),   32'h7, "wt_tl_after");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
    endtask

    task automatic test_nosel_and_reset;
        logic [7:0]  offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                                   8'h1C, 8'hF0, 8'hF4};
        exp_t        e;
        logic [31:0] got;
        wr(OFF_TCON, 32'h0);
        wr(OFF_TL,   32'hAA);
        foreach (offs[i]) begin
            addr      = {24'h0, offs[i]};
            wdata     = 32'h1234;
            mem_write = 1'b1;
            @(negedge clk);
            mem_write = 1'b0;
        end
        addr      = 32'h4001_0004;
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        push(win(OFF_TL),    32'hAA, "nosel_tl");
        push(win(OFF_TH),    32'hFFFF_FFFC, "nosel_th");
        push(win(OFF_TCON),  32'h0,  "nosel_tcon");
        push(win(OFF_PRESC), 32'h0,  "nosel_presc");
        push(32'h0000_0004,  32'h0,  "nosel_rd_low");
        push(32'h4001_0004,  32'h0,  "nosel_rd_hi");
        push(32'h0000_00F0,  32'h0,  "nosel_rd_systick");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        // Start ch0 with a prescaler so it is mid-count with status set.
        wr(OFF_PRESC, 32'h1);
        wr(OFF_TH,    32'h0);
        wr(OFF_TL,    32'hFFFF_FFFE);
        wr(OFF_TCON,  32'h3);
        repeat (6) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq: got %b, expected 1", irq);
        end
        reset = 1'b1;
        @(negedge clk);
        foreach (offs[i]) push(win(offs[i]), 32'h0, $sformatf("midrst_off_%02h", offs[i]));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, got);
            checks++;
            if (got !== e.data) begin
                failures++;
                $display("FAIL %s: got %h, expected %h", e.name, got, e.data);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL midrst_irq: got %b, expected 0", irq);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (systick !== 32'd3) begin
            failures++;
            $display("FAIL post_reset_systick: got %0d, expected 3", systick);
        end
    endtask

    initial begin
        reset     = 1'b1;
        addr      = '0;
        wdata     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_autoreload();
        test_oneshot();
        test_set_wins();
        test_write_vs_tick();
        test_nosel_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
